// File: rtl/sw_display_pkg.sv
// Shared constants, switch field layout and result arithmetic for the switch calculator display.
package sw_display_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam logic [2:0] DIG_R_LO   = 3'd0;
    localparam logic [2:0] DIG_R_HI   = 3'd1;
    localparam logic [2:0] DIG_BLANK2 = 3'd2;
    localparam logic [2:0] DIG_OP     = 3'd3;
    localparam logic [2:0] DIG_B      = 3'd4;
    localparam logic [2:0] DIG_BLANK5 = 3'd5;
    localparam logic [2:0] DIG_A      = 3'd6;
    localparam logic [2:0] DIG_BLANK7 = 3'd7;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] b;
        logic [3:0] a;
    } sw_fields_t;

    // Operands are widened to 8 bits first so subtraction wraps as two's complement.
    function automatic logic [7:0] calc_result(input sw_fields_t f);
        logic [7:0] a8;
        logic [7:0] b8;
        logic [7:0] r;
        a8 = {4'h0, f.a};
        b8 = {4'h0, f.b};
        case (f.op)
            OP_ADD:  r = a8 + b8;
            OP_SUB:  r = a8 - b8;
            OP_MUL:  r = a8 * b8;
            default: r = {4'h0, f.a ^ f.b};
        endcase
        return r;
    endfunction

    function automatic logic [7:0] anode_sel(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/sw_display_seg7_decoder.sv
// Hex nibble to active-low gfedcba segment pattern, purely combinational.
module seg7_decoder (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/sw_display.sv
// Switch calculator: synchronizes sw, computes an 8-bit result and scans result, op and operands
// onto an 8-digit multiplexed 7-segment display.
module sw_display
    import sw_display_pkg::*;
#(
    parameter int CLK_DIV     = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw,
    output logic [6:0] hex,
    output logic [7:0] AN
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [SYNC_STAGES-1:0][9:0] sync_q, sync_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [2:0]                  idx_q, idx_d;
    logic [7:0]                  an_q, an_d;
    logic [6:0]                  hex_q, hex_d;

    sw_fields_t sw_s;
    logic [7:0] result;
    logic [3:0] nib;
    logic       blank;
    logic [6:0] seg;

    assign sw_s   = sw_fields_t'(sync_q[SYNC_STAGES-1]);
    assign result = calc_result(sw_s);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw};
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_MAX) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        case (idx_q)
            DIG_R_LO: nib = result[3:0];
            DIG_R_HI: nib = result[7:4];
            DIG_OP:   nib = {2'b00, sw_s.op};
            DIG_B:    nib = sw_s.b;
            DIG_A:    nib = sw_s.a;
            default:  blank = 1'b1;
        endcase
    end

    seg7_decoder u_dec (
        .nib (nib),
        .seg (seg)
    );

    // Anode and segments are registered together so a digit change never ghosts.
    always_comb begin
        an_d  = blank ? AN_OFF    : anode_sel(idx_q);
        hex_d = blank ? SEG_BLANK : seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            div_q  <= '0;
            idx_q  <= '0;
            an_q   <= AN_OFF;
            hex_q  <= SEG_BLANK;
        end else begin
            sync_q <= sync_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            hex_q  <= hex_d;
        end
    end

    assign AN  = an_q;
    assign hex = hex_q;

endmodule

// File: tb/tb_sw_display.sv
// Directed and swept checks of the switch calculator display at CLK_DIV=4, SYNC_STAGES=2.
module tb_sw_display;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic [6:0] hex;
    logic [7:0] AN;

    int checks;
    int errors;
    int edge_cnt;

    sw_display #(.CLK_DIV(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .hex   (hex),
        .AN    (AN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges seen since the last reset release; drives the scan-position model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [9:0] sw;
        int         digit;
        logic [6:0] exp_hex;
    } vec_t;

    vec_t       vecs[17];
    logic [6:0] seg_tab[16];
    logic [7:0] an_tab[8];
    logic [7:0] an_seq[16];

    function automatic logic [7:0] ref_r(input logic [9:0] s);
        logic [3:0] a, b;
        logic [1:0] op;
        int         v;
        a  = s[3:0];
        b  = s[7:4];
        op = s[9:8];
        case (op)
            2'd0:    v = int'(a) + int'(b);
            2'd1:    v = int'(a) - int'(b) + 256;
            2'd2:    v = int'(a) * int'(b);
            default: v = int'(a ^ b);
        endcase
        return v[7:0];
    endfunction

    function automatic logic [6:0] ref_hex(input logic [9:0] s, input int idx);
        logic [7:0] r;
        r = ref_r(s);
        case (idx)
            0:       return seg_tab[r[3:0]];
            1:       return seg_tab[r[7:4]];
            3:       return seg_tab[{2'b00, s[9:8]}];
            4:       return seg_tab[s[7:4]];
            6:       return seg_tab[s[3:0]];
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
        end
    endtask

    task automatic wait_an(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (AN === target) ok = 1'b1;
        end
    endtask

    // Compares AN/hex every cycle with the scan model, assuming sw has settled.
    task automatic check_frame(input logic [9:0] s, input int cycles);
        int         idx;
        int         zeros;
        logic [7:0] exp_an;
        logic [6:0] exp_hx;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (edge_cnt == 0) begin
                exp_an = 8'hFF;
                exp_hx = 7'h7F;
            end else begin
                idx    = ((edge_cnt - 1) / 4) % 8;
                exp_an = an_tab[idx];
                exp_hx = ref_hex(s, idx);
            end
            zeros = 0;
            for (int k = 0; k < 8; k++) if (AN[k] === 1'b0) zeros++;
            check("an_onehot", {7'd0, zeros <= 1}, 8'd1);
            check("frame_an", AN, exp_an);
            check("frame_hex", {1'b0, hex}, {1'b0, exp_hx});
        end
    endtask

    initial begin
        bit         ok;
        logic [9:0] s;
        checks = 0;
        errors = 0;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        an_tab  = '{8'hFE, 8'hFD, 8'hFF, 8'hF7, 8'hEF, 8'hFF, 8'hBF, 8'hFF};
        vecs[0]  = '{10'h089, 0, 7'h79};
        vecs[1]  = '{10'h089, 1, 7'h79};
        vecs[2]  = '{10'h089, 3, 7'h40};
        vecs[3]  = '{10'h089, 4, 7'h00};
        vecs[4]  = '{10'h089, 6, 7'h10};
        vecs[5]  = '{10'h153, 0, 7'h06};
        vecs[6]  = '{10'h153, 1, 7'h0E};
        vecs[7]  = '{10'h135, 0, 7'h24};
        vecs[8]  = '{10'h2FF, 0, 7'h79};
        vecs[9]  = '{10'h2FF, 1, 7'h06};
        vecs[10] = '{10'h2FF, 3, 7'h24};
        vecs[11] = '{10'h35A, 0, 7'h0E};
        vecs[12] = '{10'h35A, 1, 7'h40};
        vecs[13] = '{10'h35A, 3, 7'h30};
        vecs[14] = '{10'h35A, 4, 7'h12};
        vecs[15] = '{10'h35A, 6, 7'h08};
        vecs[16] = '{10'h135, 1, 7'h40};

        // Reset held with all switches up: display dark.
        rst_n = 1'b0;
        sw    = 10'h3FF;
        repeat (3) @(negedge clk);
        check("rst_an", AN, 8'hFF);
        check("rst_hex", {1'b0, hex}, 8'h7F);

        // Release: digit 0 lights on the first edge, then steps every 4 clocks.
        rst_n = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            an_seq[n] = AN;
        end
        check("scan_d0_first", an_seq[0], 8'hFE);
        check("scan_d0_last", an_seq[3], 8'hFE);
        check("scan_d1", an_seq[4], 8'hFD);
        check("scan_d2_dark", an_seq[8], 8'hFF);
        check("scan_d3", an_seq[12], 8'hF7);
        check("scan_d3_last", an_seq[15], 8'hF7);

        // Directed vectors: value shown when the target digit comes round.
        for (int i = 0; i < 17; i++) begin
            sw = vecs[i].sw;
            repeat (3) @(negedge clk);
            wait_an(an_tab[vecs[i].digit], ok);
            check("vec_seen", {7'd0, ok}, 8'd1);
            if (ok) check($sformatf("vec%0d_hex", i), {1'b0, hex}, {1'b0, vecs[i].exp_hex});
        end

        // Full-frame checks including blank slots 2/5/7.
        sw = 10'h35A;
        repeat (3) @(negedge clk);
        check_frame(10'h35A, 32);

        // Random sweep; sw changes mid-slot and must be visible within 3 clocks.
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 16; i++) begin
                s  = {op[1:0], 8'($urandom_range(0, 255))};
                sw = s;
                repeat (3) @(negedge clk);
                check_frame(s, 32 + int'($urandom_range(0, 5)));
            end
        end

        // Mid-scan reset blanks immediately, before any further clock edge.
        wait_an(8'hEF, ok);
        check("pre_rst_seen", {7'd0, ok}, 8'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_an", AN, 8'hFF);
        check("midrst_hex", {1'b0, hex}, 8'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_an", AN, 8'hFE);
        sw = 10'h089;
        repeat (3) @(negedge clk);
        check_frame(10'h089, 36);

        // CLK_DIV sanity at the sweep's end: one-hot and model agreement already covered.
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
